// File: rtl/inst_prefetch_unit.sv
// inst_prefetch_unit: keeps up to DEPTH in-order fetches in flight and buffers the returned words with their PCs.
module inst_prefetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(4)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] mem_req_pc,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  input  logic                  mem_rsp_valid,
  output logic                  mem_rsp_ready,
  output logic [DATA_WIDTH-1:0] core_inst,
  output logic [ADDR_WIDTH-1:0] core_pc,
  output logic                  core_inst_valid,
  input  logic                  core_inst_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [31:0]           perf_drop_cnt
);
  localparam int CW = $clog2(DEPTH) + 2;
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {REQ_IDLE, REQ_WAIT} req_state_t;

  req_state_t            r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_req_pc, r_fetch_pc, r_rsp_pc, r_head_pc, w_fetch_nxt, w_head_pc;
  logic [DATA_WIDTH-1:0] r_head_inst, w_head_inst;
  logic [CW-1:0]         r_count, r_live, r_stale, w_count_nxt, w_live_nxt, w_stale_nxt;
  logic [PW-1:0]         r_rd_ptr, r_wr_ptr, w_rd_nxt;
  logic                  r_tag, r_rsp_ready, r_head_valid;
  logic [31:0]           r_drop_cnt;
  logic [ADDR_WIDTH-1:0] r_mem_pc [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_inst [DEPTH];
  logic                  w_acc, w_rsp, w_drop, w_push, w_pop, w_credit, w_issue, w_load;

  assign mem_req_pc      = r_req_pc;
  assign mem_req_valid   = (r_state == REQ_WAIT);
  assign mem_rsp_ready   = r_rsp_ready;
  assign core_inst       = r_head_inst;
  assign core_pc         = r_head_pc;
  assign core_inst_valid = r_head_valid;
  assign perf_drop_cnt   = r_drop_cnt;

  assign w_acc  = (r_state == REQ_WAIT) & mem_req_ready;
  assign w_rsp  = mem_rsp_valid & r_rsp_ready;
  // Responses in a redirect cycle belong to the old stream, even if nothing was stale yet.
  assign w_drop = w_rsp & (redirect_valid | (r_stale != '0));
  assign w_push = w_rsp & ~w_drop;
  assign w_pop  = r_head_valid & core_inst_ready;

  always_comb begin
    w_count_nxt = redirect_valid ? '0 : r_count + CW'(w_push) - CW'(w_pop);
    w_live_nxt  = redirect_valid ? '0 : r_live + CW'(w_acc & ~r_tag) - CW'(w_push);
    w_stale_nxt = redirect_valid ? r_stale + r_live + CW'(w_acc) - CW'(w_rsp)
                                 : r_stale + CW'(w_acc & r_tag) - CW'(w_drop);
    w_fetch_nxt = redirect_valid ? redirect_pc : (w_acc & ~r_tag) ? r_fetch_pc + INC : r_fetch_pc;
    w_rd_nxt    = redirect_valid ? '0 : r_rd_ptr + PW'(w_pop);
    w_credit    = ({1'b0, w_count_nxt} + {1'b0, w_live_nxt} < (CW+1)'(DEPTH)) &&
                  ({1'b0, w_live_nxt} + {1'b0, w_stale_nxt} < (CW+1)'(2*DEPTH-1));
    w_issue     = r_rsp_ready & ~redirect_valid & w_credit;
    w_head_inst = (w_push && w_rd_nxt == r_wr_ptr) ? mem_rsp_data : r_mem_inst[w_rd_nxt];
    w_head_pc   = (w_push && w_rd_nxt == r_wr_ptr) ? r_rsp_pc : r_mem_pc[w_rd_nxt];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    if (r_state == REQ_IDLE || w_acc) begin
      w_state_nxt = w_issue ? REQ_WAIT : REQ_IDLE;
      w_load      = w_issue;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= REQ_IDLE;
    else r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_pc     <= RESET_PC;
      r_fetch_pc   <= RESET_PC;
      r_rsp_pc     <= RESET_PC;
      r_tag        <= 1'b0;
      r_rsp_ready  <= 1'b0;
      r_count      <= '0;
      r_live       <= '0;
      r_stale      <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_drop_cnt   <= '0;
      r_head_valid <= 1'b0;
      r_head_inst  <= '0;
      r_head_pc    <= '0;
    end else begin
      r_rsp_ready  <= 1'b1;
      r_req_pc     <= w_load ? w_fetch_nxt : r_req_pc;
      // A pending request hit by a redirect still completes, but its response is dropped.
      r_tag        <= w_load ? 1'b0 : r_tag | (redirect_valid & (r_state == REQ_WAIT) & ~w_acc);
      r_fetch_pc   <= w_fetch_nxt;
      r_rsp_pc     <= redirect_valid ? redirect_pc : w_push ? r_rsp_pc + INC : r_rsp_pc;
      r_count      <= w_count_nxt;
      r_live       <= w_live_nxt;
      r_stale      <= w_stale_nxt;
      r_rd_ptr     <= w_rd_nxt;
      r_wr_ptr     <= redirect_valid ? '0 : r_wr_ptr + PW'(w_push);
      r_drop_cnt   <= r_drop_cnt + 32'(w_drop);
      r_head_valid <= (w_count_nxt != '0);
      r_head_inst  <= (w_count_nxt != '0) ? w_head_inst : r_head_inst;
      r_head_pc    <= (w_count_nxt != '0) ? w_head_pc : r_head_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_inst[r_wr_ptr] <= mem_rsp_data;
      r_mem_pc[r_wr_ptr]   <= r_rsp_pc;
    end
  end
endmodule

// File: doc/inst_prefetch_unit.md
# inst_prefetch_unit

Parametrised instruction prefetch unit between the multi-cycle core's fetch stage and the instruction memory request/response channels. It replaces the core's single-outstanding fetch with up to DEPTH in-order requests in flight. Fetched words are buffered with their PCs in a FIFO. Redirects (taken branches and jumps) flush the buffer and squash stale responses.

## Interface
- ADDR_WIDTH, 32, PC/address width.
- DATA_WIDTH, 32, instruction word width.
- DEPTH, 4, FIFO entries and maximum live requests; power of two, ≥2.
- RESET_PC, 0, first fetch address after reset.
- INC, 4, sequential PC increment.

Ports:
- clk  input  1  clock; all state on posedge.
- rst  input  1  asynchronous, active-low reset.
- mem_req_pc  output  ADDR_WIDTH  request address (drives PC).
- mem_req_valid  output  1  request valid (Inst_Req_Valid).
- mem_req_ready  input  1  request accepted (Inst_Req_Ready).
- mem_rsp_data  input  DATA_WIDTH  returned word (Instruction).
- mem_rsp_valid  input  1  response valid (Inst_Valid).
- mem_rsp_ready  output  1  response ready (Inst_Ready).
- core_inst  output  DATA_WIDTH  FIFO head instruction.
- core_pc  output  ADDR_WIDTH  PC of head instruction.
- core_inst_valid  output  1  head valid.
- core_inst_ready  input  1  core consumes head.
- redirect_valid  input  1  one-cycle flush/redirect strobe.
- redirect_pc  input  ADDR_WIDTH  new fetch address.
- perf_drop_cnt  output  32  count of discarded (stale) responses.

## Operation
- Registers:
  - fetch_pc: next address to request.
  - FIFO of {pc, inst}, DEPTH entries, with count.
  - live: accepted, non-stale requests awaiting response.
  - stale: accepted requests whose responses must be dropped.
  - req FSM.
- Request FSM states:
  - REQ_IDLE, REQ_WAIT.
  - IDLE→WAIT when count+live < DEPTH and live+stale < 2·DEPTH−1, no redirect this cycle. mem_req_pc latches fetch_pc; mem_req_valid=1.
  - WAIT: mem_req_valid and mem_req_pc held stable until mem_req_ready. On accept, fetch_pc += INC, live++ (or stale++ if tagged stale).
  - WAIT→WAIT on accept if the credit condition still holds after accounting; otherwise →IDLE.
- A WAIT request is never withdrawn. A redirect while in WAIT tags the pending request stale; it completes normally.
- Response path:
  - mem_rsp_ready=1 whenever out of reset; space is pre-reserved by credits.
  - A response with stale>0 is discarded: stale--, perf_drop_cnt++.
  - Otherwise it is pushed with its PC (tracked by a rsp_pc counter, +INC per push), and live--.
- Core side: core_inst_valid = count≠0. Pop on core_inst_valid & core_inst_ready.
- Redirect (redirect_valid=1) in cycle t:
  - FIFO flushed (count←0). A pop in the same cycle is accepted, then flushed.
  - stale ← stale + live + (1 if accepted this cycle), minus 1 if a response arrives this cycle. live←0.
  - A response in cycle t belongs to the old stream and is discarded.
  - fetch_pc ← redirect_pc; rsp_pc ← redirect_pc.
- perf_drop_cnt wraps modulo 2^32.
- Counter widths: $clog2(DEPTH)+2 bits; overflow impossible by the credit rule.
- Reset mid-operation clears all state immediately, including in-flight bookkeeping. Memory responses arriving during reset are ignored (mem_rsp_ready=0).

## Timing
- Reset values:
  - mem_req_valid=0, mem_req_pc=RESET_PC, mem_rsp_ready=0.
  - core_inst_valid=0, core_inst=0, core_pc=0, perf_drop_cnt=0.
  - FSM=REQ_IDLE, fetch_pc=RESET_PC.
- First cycle after rst rises: mem_rsp_ready=1. mem_req_valid=1 with mem_req_pc=RESET_PC on the following edge (1-cycle start).
- Back-to-back issue: one request per cycle while mem_req_ready=1 and credits remain.
- Response to core: word accepted at edge N is visible on core_inst/core_inst_valid after edge N (1-cycle latency). No combinational path mem_rsp→core.
- Redirect at edge t:
  - core_inst_valid=0 after t.
  - If FSM was IDLE, the first request to redirect_pc asserts after t (1 cycle).
  - If FSM was WAIT, the request to redirect_pc asserts in the cycle after the stale request is accepted.
- Full: count+live = DEPTH → mem_req_valid stays 0 until a pop.
- Empty: core_inst_valid=0; core_inst/core_pc hold the last head value.
- Outputs are register-driven except mem_rsp_ready (registered, derived from reset only).

## Test plan
- Reset release, mem_req_ready=1, memory returns word = address+0x1000 with 1-cycle delay, core ready always → requests 0x0,0x4,0x8…; core sees pc 0x0/inst 0x1000, then 0x4/0x1004, one per cycle after fill.
- Core ready=0, DEPTH=4 → exactly 4 requests issued; mem_req_valid stays 0. One pop → exactly one more request, to 0x10.
- mem_req_ready held 0 for 5 cycles → mem_req_valid=1 and mem_req_pc=0x0 stable for all 5 cycles. No second request.
- 3 requests in flight (0x0,0x4,0x8), redirect_valid to 0x400 → next request 0x400. Three responses dropped; perf_drop_cnt=3. First core_pc=0x400.
- Redirect in the same cycle as a response and a core pop → response discarded, FIFO empty next cycle, perf_drop_cnt+1, no duplicate or lost instruction at 0x400.
- Assert rst low mid-stream with 2 in flight → all outputs at reset values next cycle. After release, fetch restarts at RESET_PC with perf_drop_cnt=0.
